// File: rtl/csr_pkg.sv
// csr_pkg: shared encodings, CSR addresses, opcode/funct3 constants and the SYSTEM decoder.
package csr_pkg;

    localparam logic [1:0] CSR_ST_IDLE  = 2'b00;
    localparam logic [1:0] CSR_ST_RW    = 2'b01;
    localparam logic [1:0] CSR_ST_ECALL = 2'b10;
    localparam logic [1:0] CSR_ST_MRET  = 2'b11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_DONE_ILL
    } csr_fsm_e;

    typedef enum logic [2:0] {
        OP_RW,
        OP_RS,
        OP_RC,
        OP_ECALL,
        OP_MRET,
        OP_ILL
    } csr_op_e;

    // Immediate forms decode only when imm_en is set; otherwise they fall to OP_ILL.
    function automatic csr_op_e csr_decode(input logic [31:0] inst, input logic imm_en);
        logic [2:0] f3;
        logic       imm_ok;
        f3     = inst[14:12];
        imm_ok = imm_en || !inst[14];
        if (inst[6:0] != OPC_SYSTEM) return OP_ILL;
        if (f3 == F3_PRIV)
            return inst == INST_ECALL ? OP_ECALL : inst == INST_MRET ? OP_MRET : OP_ILL;
        if (!imm_ok || f3 == 3'b100) return OP_ILL;
        return f3[1:0] == 2'b01 ? OP_RW : f3[1:0] == 2'b10 ? OP_RS : OP_RC;
    endfunction

endpackage

// File: rtl/csr_issue_if.sv
// csr_issue_if: ID issue port, CSR file port, write-back and redirect signals of csr_issue.
interface csr_issue_if;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] inst_i;
    logic [63:0] pc_i;
    logic [63:0] rs1_data_i;
    logic [1:0]  csr_state_o;
    logic [11:0] csr_r_addr_o;
    logic        csr_ren_o;
    logic [11:0] csr_w_addr_o;
    logic        csr_wen_o;
    logic [63:0] csr_w_data_o;
    logic [63:0] csr_pc_o;
    logic [63:0] csr_r_data_i;
    logic [63:0] csr_dnpc_i;
    logic        rd_wen_o;
    logic [4:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic        redirect_o;
    logic [63:0] redirect_pc_o;
    logic        done_o;
    logic        illegal_o;

    modport slave (
        input  valid_i, inst_i, pc_i, rs1_data_i, csr_r_data_i, csr_dnpc_i,
        output ready_o, csr_state_o, csr_r_addr_o, csr_ren_o, csr_w_addr_o, csr_wen_o,
               csr_w_data_o, csr_pc_o, rd_wen_o, rd_addr_o, rd_data_o,
               redirect_o, redirect_pc_o, done_o, illegal_o
    );

    modport master (
        output valid_i, inst_i, pc_i, rs1_data_i, csr_r_data_i, csr_dnpc_i,
        input  ready_o, csr_state_o, csr_r_addr_o, csr_ren_o, csr_w_addr_o, csr_wen_o,
               csr_w_data_o, csr_pc_o, rd_wen_o, rd_addr_o, rd_data_o,
               redirect_o, redirect_pc_o, done_o, illegal_o
    );
endinterface

// File: rtl/csr_alu.sv
// csr_alu: read-modify-write value for CSRRW/S/C and the write-suppress flag for zero rs1/uimm.
import csr_pkg::*;

module csr_alu (
    input  csr_op_e     op,
    input  logic [63:0] old,
    input  logic [63:0] src,
    input  logic [4:0]  rs1_idx,
    output logic [63:0] new_val,
    output logic        wr_sup
);
    assign new_val = op == OP_RS ? old | src : op == OP_RC ? old & ~src : src;
    assign wr_sup  = (op == OP_RS || op == OP_RC) && rs1_idx == 5'd0;
endmodule

// File: rtl/csr_issue.sv
// csr_issue: multi-cycle issue FSM for SYSTEM-class instructions (CSR ops, ECALL, MRET).
// Define CSR_IMM_EN to execute the CSRR*I immediate forms; otherwise they retire as illegal.
import csr_pkg::*;

module csr_issue (
    input logic         clk,
    input logic         rst_n,
    csr_issue_if.slave  bus
);
`ifdef CSR_IMM_EN
    localparam logic IMM_EN = 1'b1;
`else
    localparam logic IMM_EN = 1'b0;
`endif

    csr_fsm_e    state;
    logic [31:0] inst_q;
    logic [63:0] pc_q;
    logic [63:0] rs1_q;
    logic [63:0] old_q;
    csr_op_e     op;
    csr_op_e     in_op;
    logic [63:0] src;
    logic [63:0] new_val;
    logic        wr_sup;
    logic [4:0]  rd;
    logic        rd_st;
    logic        wr_st;
    logic        trap_st;

    assign op    = csr_decode(inst_q, IMM_EN);
    assign in_op = csr_decode(bus.inst_i, IMM_EN);
    assign src   = inst_q[14] ? {59'd0, inst_q[19:15]} : rs1_q;
    assign rd    = inst_q[11:7];

    csr_alu u_alu (
        .op      (op),
        .old     (old_q),
        .src     (src),
        .rs1_idx (inst_q[19:15]),
        .new_val (new_val),
        .wr_sup  (wr_sup)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            inst_q <= '0;
            pc_q   <= '0;
            rs1_q  <= '0;
            old_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.valid_i) begin
                    inst_q <= bus.inst_i;
                    pc_q   <= bus.pc_i;
                    rs1_q  <= bus.rs1_data_i;
                    state  <= in_op inside {OP_RW, OP_RS, OP_RC} ? S_READ :
                              in_op inside {OP_ECALL, OP_MRET} ? S_TRAP : S_DONE_ILL;
                end
                S_READ: begin
                    old_q <= bus.csr_r_data_i;
                    state <= S_WRITE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rd_st   = state == S_READ;
    assign wr_st   = state == S_WRITE;
    assign trap_st = state == S_TRAP;

    assign bus.ready_o       = state == S_IDLE;
    assign bus.csr_state_o   = (rd_st || wr_st) ? CSR_ST_RW :
                               trap_st ? (op == OP_MRET ? CSR_ST_MRET : CSR_ST_ECALL) : CSR_ST_IDLE;
    assign bus.csr_r_addr_o  = rd_st ? inst_q[31:20] : 12'd0;
    // CSRRW(I) to x0 must not cause read side effects.
    assign bus.csr_ren_o     = rd_st && !(op == OP_RW && rd == 5'd0);
    assign bus.csr_w_addr_o  = wr_st ? inst_q[31:20] : 12'd0;
    assign bus.csr_wen_o     = wr_st && !wr_sup;
    assign bus.csr_w_data_o  = wr_st ? new_val : 64'd0;
    assign bus.csr_pc_o      = state != S_IDLE ? pc_q : 64'd0;
    assign bus.rd_wen_o      = wr_st && rd != 5'd0;
    assign bus.rd_addr_o     = wr_st ? rd : 5'd0;
    assign bus.rd_data_o     = wr_st ? old_q : 64'd0;
    assign bus.redirect_o    = trap_st;
    assign bus.redirect_pc_o = trap_st ? bus.csr_dnpc_i : 64'd0;
    assign bus.done_o        = wr_st || trap_st || state == S_DONE_ILL;
    assign bus.illegal_o     = state == S_DONE_ILL;
endmodule

// File: tb/tb_csr_issue.sv
// tb_csr_issue: directed self-checking bench for csr_issue (honours CSR_IMM_EN for immediate forms).
import csr_pkg::*;

module tb_csr_issue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    csr_issue_if bus ();

    csr_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] csr_inst(input logic [11:0] csr, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, OPC_SYSTEM};
    endfunction

    task automatic issue(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] rs1);
        bus.inst_i     = inst;
        bus.pc_i       = pc;
        bus.rs1_data_i = rs1;
        bus.valid_i    = 1'b1;
        tick();
        bus.valid_i    = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.valid_i      = 1'b0;
        bus.inst_i       = '0;
        bus.pc_i         = '0;
        bus.rs1_data_i   = '0;
        bus.csr_r_data_i = '0;
        bus.csr_dnpc_i   = '0;
        tick();
        tick();
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_state", 64'(bus.csr_state_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_pc", bus.csr_pc_o, 64'd0);
        rst_n = 1'b1;

        // CSRRW x5, mtvec, x6
        issue(csr_inst(CSR_MTVEC, 5'd6, F3_CSRRW, 5'd5), 64'h8000_0000, 64'h8000_0000);
        chk("rw_rd_state", 64'(bus.csr_state_o), 64'd1);
        chk("rw_rd_ready", 64'(bus.ready_o), 64'd0);
        chk("rw_rd_addr", 64'(bus.csr_r_addr_o), 64'h305);
        chk("rw_rd_ren", 64'(bus.csr_ren_o), 64'd1);
        chk("rw_rd_done", 64'(bus.done_o), 64'd0);
        bus.csr_r_data_i = 64'h10;
        tick();
        bus.csr_r_data_i = 64'hdead_beef;
        chk("rw_wdata", bus.csr_w_data_o, 64'h8000_0000);
        chk("rw_wen", 64'(bus.csr_wen_o), 64'd1);
        chk("rw_waddr", 64'(bus.csr_w_addr_o), 64'h305);
        chk("rw_rd_data", bus.rd_data_o, 64'h10);
        chk("rw_rd_addr", 64'(bus.rd_addr_o), 64'd5);
        chk("rw_rd_wen", 64'(bus.rd_wen_o), 64'd1);
        chk("rw_done", 64'(bus.done_o), 64'd1);
        chk("rw_ill", 64'(bus.illegal_o), 64'd0);
        tick();
        chk("rw_idle_ready", 64'(bus.ready_o), 64'd1);
        chk("rw_idle_done", 64'(bus.done_o), 64'd0);
        chk("rw_idle_wen", 64'(bus.csr_wen_o), 64'd0);

        // CSRRS x0, mstatus, x0 with valid_i held high throughout
        bus.inst_i      = csr_inst(CSR_MSTATUS, 5'd0, F3_CSRRS, 5'd0);
        bus.rs1_data_i  = 64'h55;
        bus.valid_i     = 1'b1;
        bus.csr_r_data_i = 64'h88;
        tick();
        chk("rs0_ren", 64'(bus.csr_ren_o), 64'd1);
        tick();
        chk("rs0_wen", 64'(bus.csr_wen_o), 64'd0);
        chk("rs0_rd_wen", 64'(bus.rd_wen_o), 64'd0);
        chk("rs0_done", 64'(bus.done_o), 64'd1);
        tick();
        chk("b2b_idle_ready", 64'(bus.ready_o), 64'd1);
        chk("b2b_idle_state", 64'(bus.csr_state_o), 64'd0);
        tick();
        bus.valid_i = 1'b0;
        chk("b2b_reaccept", 64'(bus.csr_state_o), 64'd1);
        tick();
        tick();

        // CSRRC x10, mstatus, x7 with rs1=0x8, mstatus=0x88
        issue(csr_inst(CSR_MSTATUS, 5'd7, F3_CSRRC, 5'd10), 64'h8000_0010, 64'h8);
        bus.csr_r_data_i = 64'h88;
        tick();
        chk("rc_wdata", bus.csr_w_data_o, 64'h80);
        chk("rc_wen", 64'(bus.csr_wen_o), 64'd1);
        chk("rc_rd_data", bus.rd_data_o, 64'h88);
        chk("rc_pc", bus.csr_pc_o, 64'h8000_0010);
        tick();

        // ECALL
        bus.csr_dnpc_i = 64'h8000_0400;
        issue(INST_ECALL, 64'h8000_0100, 64'h0);
        chk("ecall_state", 64'(bus.csr_state_o), 64'd2);
        chk("ecall_pc", bus.csr_pc_o, 64'h8000_0100);
        chk("ecall_redir", 64'(bus.redirect_o), 64'd1);
        chk("ecall_rpc", bus.redirect_pc_o, 64'h8000_0400);
        chk("ecall_done", 64'(bus.done_o), 64'd1);
        chk("ecall_ill", 64'(bus.illegal_o), 64'd0);
        chk("ecall_wen", 64'(bus.csr_wen_o), 64'd0);
        tick();
        chk("ecall_after_redir", 64'(bus.redirect_o), 64'd0);
        chk("ecall_after_ready", 64'(bus.ready_o), 64'd1);

        // MRET
        bus.csr_dnpc_i = 64'h8000_0104;
        issue(INST_MRET, 64'h8000_0200, 64'h0);
        chk("mret_state", 64'(bus.csr_state_o), 64'd3);
        chk("mret_redir", 64'(bus.redirect_o), 64'd1);
        chk("mret_rpc", bus.redirect_pc_o, 64'h8000_0104);
        chk("mret_done", 64'(bus.done_o), 64'd1);
        tick();

        // CSRRSI x1, mstatus, 5
        bus.csr_r_data_i = 64'h30;
        issue(csr_inst(CSR_MSTATUS, 5'd5, F3_CSRRSI, 5'd1), 64'h8000_0300, 64'hffff);
`ifdef CSR_IMM_EN
        chk("rsi_state", 64'(bus.csr_state_o), 64'd1);
        tick();
        chk("rsi_wdata", bus.csr_w_data_o, 64'h35);
        chk("rsi_wen", 64'(bus.csr_wen_o), 64'd1);
        chk("rsi_rd_data", bus.rd_data_o, 64'h30);
`else
        chk("rsi_ill", 64'(bus.illegal_o), 64'd1);
        chk("rsi_done", 64'(bus.done_o), 64'd1);
        chk("rsi_state", 64'(bus.csr_state_o), 64'd0);
        chk("rsi_ren", 64'(bus.csr_ren_o), 64'd0);
        chk("rsi_rd_wen", 64'(bus.rd_wen_o), 64'd0);
`endif
        tick();
        chk("rsi_after_ready", 64'(bus.ready_o), 64'd1);

        // EBREAK and a non-SYSTEM opcode both retire as illegal
        issue(32'h0010_0073, 64'h8000_0400, 64'h0);
        chk("ebreak_ill", 64'(bus.illegal_o), 64'd1);
        chk("ebreak_done", 64'(bus.done_o), 64'd1);
        chk("ebreak_redir", 64'(bus.redirect_o), 64'd0);
        tick();
        issue(32'h0000_0013, 64'h8000_0404, 64'h0);
        chk("nonsys_ill", 64'(bus.illegal_o), 64'd1);
        tick();
        chk("ill_after", 64'(bus.illegal_o), 64'd0);

        // Reset during READ aborts the write
        issue(csr_inst(CSR_MEPC, 5'd6, F3_CSRRW, 5'd5), 64'h8000_0500, 64'h1234);
        chk("abort_in_read", 64'(bus.csr_state_o), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_wen", 64'(bus.csr_wen_o), 64'd0);
        chk("abort_done", 64'(bus.done_o), 64'd0);
        chk("abort_rd_wen", 64'(bus.rd_wen_o), 64'd0);
        chk("abort_ready", 64'(bus.ready_o), 64'd1);
        chk("abort_pc", bus.csr_pc_o, 64'd0);
        tick();
        chk("abort_stay_idle", 64'(bus.done_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
